// File: rtl/elgamal_if.sv
// Stream bundle for the ElGamal encryptor: key, message, ephemeral exponent in; ciphertext out.
interface elgamal_if #(
  parameter int unsigned SIZE = 64
);
  logic [3*SIZE-1:0] key_tdata;
  logic              key_tvalid;
  logic              key_tready;
  logic [SIZE-1:0]   msg_tdata;
  logic              msg_tvalid;
  logic              msg_tready;
  logic [SIZE-1:0]   eph_tdata;
  logic              eph_tvalid;
  logic              eph_tready;
  logic [2*SIZE-1:0] ct_tdata;
  logic              ct_tvalid;
  logic              ct_tready;
  logic              err;

  modport master (
    output key_tdata, key_tvalid, msg_tdata, msg_tvalid, eph_tdata, eph_tvalid, ct_tready,
    input  key_tready, msg_tready, eph_tready, ct_tdata, ct_tvalid, err
  );

  modport slave (
    input  key_tdata, key_tvalid, msg_tdata, msg_tvalid, eph_tdata, eph_tvalid, ct_tready,
    output key_tready, msg_tready, eph_tready, ct_tdata, ct_tvalid, err
  );
endinterface

// File: rtl/elgamal_encryptor.sv
// Constant-time ElGamal encryptor: c1 = g^k mod p, c2 = m*h^k mod p via bit-serial modmul.
// Optional operand range check enabled by defining ELGAMAL_ENC_RANGE_CHECK_EN.
module elgamal_encryptor #(
  parameter int unsigned SIZE = 64
) (
  input logic       clk,
  input logic       rst,
  elgamal_if.slave  bus
);
  localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] CntMax = CW'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, EXP_SQ, EXP_MUL, MSG_MUL, OUT} state_e;

  state_e            r_state;
  logic [SIZE-1:0]   r_p, r_g, r_h, r_m, r_k;
  logic [SIZE-1:0]   r_acc_g, r_acc_h;
  logic [SIZE-1:0]   r_pg, r_ph;
  logic [CW-1:0]     r_cnt, r_bit;
  logic              r_key_loaded;
  logic              r_rdy;
  logic              r_out_stage;
  logic [2*SIZE-1:0] r_ct_tdata;
  logic              r_ct_tvalid;

  logic              w_idle, w_req_rdy, w_bad;
  logic [SIZE-1:0]   w_a_g, w_b_g, w_a_h, w_b_h, w_ng, w_nh;

  // One shift-add step; 2r + a < 3p, so two conditional subtractions fully reduce.
  function automatic logic [SIZE-1:0] mod_step(input logic [SIZE-1:0] r, input logic [SIZE-1:0] a,
                                               input logic [SIZE-1:0] p, input logic b);
    logic [SIZE+1:0] t;
    t = {1'b0, r, 1'b0} + (b ? {2'b00, a} : '0);
    if (t >= {2'b00, p}) t = t - {2'b00, p};
    if (t >= {2'b00, p}) t = t - {2'b00, p};
    return t[SIZE-1:0];
  endfunction

  assign w_idle         = (r_state == IDLE);
  assign w_req_rdy      = w_idle & r_key_loaded & bus.msg_tvalid & bus.eph_tvalid & ~bus.key_tvalid;
  assign bus.key_tready = w_idle & r_rdy;
  assign bus.msg_tready = w_req_rdy;
  assign bus.eph_tready = w_req_rdy;
  assign bus.ct_tdata   = r_ct_tdata;
  assign bus.ct_tvalid  = r_ct_tvalid;

`ifdef ELGAMAL_ENC_RANGE_CHECK_EN
  logic r_err;
  assign w_bad   = (bus.msg_tdata >= r_p) | (r_g >= r_p) | (r_h >= r_p) | (r_p < SIZE'(3));
  assign bus.err = r_err;
`else
  assign w_bad   = 1'b0;
  assign bus.err = 1'b0;
`endif

  // Multiplier operand routing; the multiplicand scanned bit-serially is always the b operand.
  always_comb begin
    w_a_g = r_acc_g;
    w_b_g = r_acc_g;
    w_a_h = r_acc_h;
    w_b_h = r_acc_h;
    case (r_state)
      EXP_MUL: begin
        w_b_g = r_g;
        w_b_h = r_h;
      end
      MSG_MUL: begin
        w_b_g = '0;
        w_b_h = r_m;
      end
      default: ;
    endcase
  end

  assign w_ng = mod_step(r_pg, w_a_g, r_p, w_b_g[r_cnt]);
  assign w_nh = mod_step(r_ph, w_a_h, r_p, w_b_h[r_cnt]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_p          <= '0;
      r_g          <= '0;
      r_h          <= '0;
      r_m          <= '0;
      r_k          <= '0;
      r_acc_g      <= '0;
      r_acc_h      <= '0;
      r_pg         <= '0;
      r_ph         <= '0;
      r_cnt        <= CntMax;
      r_bit        <= CntMax;
      r_key_loaded <= 1'b0;
      r_rdy        <= 1'b0;
      r_out_stage  <= 1'b0;
      r_ct_tdata   <= '0;
      r_ct_tvalid  <= 1'b0;
`ifdef ELGAMAL_ENC_RANGE_CHECK_EN
      r_err        <= 1'b0;
`endif
    end else begin
      r_rdy <= 1'b1;
`ifdef ELGAMAL_ENC_RANGE_CHECK_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (bus.key_tvalid && bus.key_tready) begin
            r_p          <= bus.key_tdata[3*SIZE-1:2*SIZE];
            r_g          <= bus.key_tdata[2*SIZE-1:SIZE];
            r_h          <= bus.key_tdata[SIZE-1:0];
            r_key_loaded <= 1'b1;
          end else if (w_req_rdy) begin
            if (w_bad) begin
`ifdef ELGAMAL_ENC_RANGE_CHECK_EN
              r_err <= 1'b1;
`endif
            end else begin
              r_m     <= bus.msg_tdata;
              r_k     <= bus.eph_tdata;
              r_acc_g <= SIZE'(1);
              r_acc_h <= SIZE'(1);
              r_pg    <= '0;
              r_ph    <= '0;
              r_cnt   <= CntMax;
              r_bit   <= CntMax;
              r_state <= EXP_SQ;
            end
          end
        end
        EXP_SQ: begin
          r_pg  <= w_ng;
          r_ph  <= w_nh;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_acc_g <= w_ng;
            r_acc_h <= w_nh;
            r_pg    <= '0;
            r_ph    <= '0;
            r_cnt   <= CntMax;
            r_state <= EXP_MUL;
          end
        end
        EXP_MUL: begin
          r_pg  <= w_ng;
          r_ph  <= w_nh;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            // Product is always computed; committing it only on a set bit keeps timing k-independent.
            if (r_k[r_bit]) begin
              r_acc_g <= w_ng;
              r_acc_h <= w_nh;
            end
            r_pg  <= '0;
            r_ph  <= '0;
            r_cnt <= CntMax;
            if (r_bit == '0) begin
              r_state <= MSG_MUL;
            end else begin
              r_bit   <= r_bit - 1'b1;
              r_state <= EXP_SQ;
            end
          end
        end
        MSG_MUL: begin
          r_ph  <= w_nh;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_acc_h     <= w_nh;
            r_ph        <= '0;
            r_cnt       <= CntMax;
            r_out_stage <= 1'b0;
            r_state     <= OUT;
          end
        end
        OUT: begin
          if (!r_ct_tvalid) begin
            // Two-step presentation: register the ciphertext, then raise valid.
            if (!r_out_stage) begin
              r_ct_tdata  <= {r_acc_g, r_acc_h};
              r_out_stage <= 1'b1;
            end else begin
              r_ct_tvalid <= 1'b1;
            end
          end else if (bus.ct_tready) begin
            r_ct_tvalid <= 1'b0;
            r_out_stage <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_elgamal_encryptor.sv
// Directed + randomized bench for elgamal_encryptor (SIZE=8) against a square-and-multiply model.
module tb_elgamal_encryptor;
  localparam int unsigned SIZE = 8;
  localparam int LAT = 2 * SIZE * SIZE + SIZE + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  elgamal_if #(.SIZE(SIZE)) bus ();

  elgamal_encryptor #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int unsigned powmod(input int unsigned b, input int unsigned e,
                                         input int unsigned p);
    int unsigned r;
    r = 1 % p;
    b = b % p;
    while (e != 0) begin
      if ((e & 1) != 0) r = (r * b) % p;
      b = (b * b) % p;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [15:0] model_ct(input int unsigned p, input int unsigned g,
                                           input int unsigned h, input int unsigned m,
                                           input int unsigned k);
    int unsigned c1, c2;
    c1 = powmod(g, k, p);
    c2 = ((m % p) * powmod(h, k, p)) % p;
    return {c1[7:0], c2[7:0]};
  endfunction

  // Called at a negedge; returns at the negedge after the key transfer edge.
  task automatic load_key(input logic [7:0] p, input logic [7:0] g, input logic [7:0] h);
    bus.key_tdata  = {p, g, h};
    bus.key_tvalid = 1'b1;
    #1 check("key_tready", 64'(bus.key_tready), 64'd1);
    @(negedge clk);
    bus.key_tvalid = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the msg/eph transfer edge.
  task automatic start_req(input logic [7:0] m, input logic [7:0] k);
    int w;
    bus.msg_tdata  = m;
    bus.eph_tdata  = k;
    bus.msg_tvalid = 1'b1;
    bus.eph_tvalid = 1'b1;
    #1;
    w = 0;
    while (!bus.msg_tready && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("msg_eph_tready", 64'({bus.msg_tready, bus.eph_tready}), 64'd3);
    @(negedge clk);
    bus.msg_tvalid = 1'b0;
    bus.eph_tvalid = 1'b0;
  endtask

  task automatic wait_ct(output int lat);
    lat = 0;
    while (!bus.ct_tvalid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_ct();
    bus.ct_tready = 1'b1;
    @(negedge clk);
    bus.ct_tready = 1'b0;
    check("ct_tvalid_drop", 64'(bus.ct_tvalid), 64'd0);
    check("back_to_idle", 64'(bus.key_tready), 64'd1);
  endtask

  task automatic run_one(input string tag, input logic [7:0] m, input logic [7:0] k,
                         input logic [15:0] exp);
    int lat;
    start_req(m, k);
    wait_ct(lat);
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    check({tag, "_ct"}, 64'(bus.ct_tdata), 64'(exp));
    take_ct();
  endtask

  initial begin
    int lat, bad;
    logic [15:0] snap, exp;
    logic [7:0] p, g, h, m, k;

    bus.key_tdata  = '0;
    bus.key_tvalid = 1'b0;
    bus.msg_tdata  = '0;
    bus.msg_tvalid = 1'b0;
    bus.eph_tdata  = '0;
    bus.eph_tvalid = 1'b0;
    bus.ct_tready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ct_tvalid", 64'(bus.ct_tvalid), 64'd0);
    check("rst_ct_tdata", 64'(bus.ct_tdata), 64'd0);
    check("rst_key_tready", 64'(bus.key_tready), 64'd0);
    check("rst_msg_tready", 64'(bus.msg_tready), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_key_tready", 64'(bus.key_tready), 64'd1);

    // Reference vectors
    load_key(8'd23, 8'd5, 8'd8);
    run_one("m10_k3", 8'd10, 8'd3, 16'h0A0E);
    run_one("m7_k0", 8'd7, 8'd0, 16'h0107);
    run_one("m10_k255", 8'd10, 8'd255, model_ct(23, 5, 8, 10, 255));

    // Backpressure: ciphertext held while ct_tready low
    start_req(8'd10, 8'd3);
    wait_ct(lat);
    check("bp_lat", 64'(lat), 64'(LAT));
    snap = bus.ct_tdata;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.ct_tvalid || bus.ct_tdata !== snap) bad++;
    end
    check("bp_stable", 64'(bad), 64'd0);
    check("bp_ct", 64'(bus.ct_tdata), 64'h0A0E);
    take_ct();
    run_one("no_reload", 8'd7, 8'd0, 16'h0107);

    // Key and msg/eph valid together: key wins, request next cycle
    bus.key_tdata  = {8'd23, 8'd5, 8'd8};
    bus.key_tvalid = 1'b1;
    bus.msg_tdata  = 8'd10;
    bus.eph_tdata  = 8'd3;
    bus.msg_tvalid = 1'b1;
    bus.eph_tvalid = 1'b1;
    #1;
    check("sim_key_first", 64'(bus.key_tready), 64'd1);
    check("sim_msg_blocked", 64'(bus.msg_tready), 64'd0);
    @(negedge clk);
    bus.key_tvalid = 1'b0;
    run_one("sim", 8'd10, 8'd3, 16'h0A0E);

    // Randomized against the model
    for (int t = 0; t < 6; t++) begin
      p = 8'($urandom_range(255, 3));
      g = 8'($urandom_range(int'(p) - 1, 0));
      h = 8'($urandom_range(int'(p) - 1, 0));
      m = 8'($urandom_range(int'(p) - 1, 0));
      k = 8'($urandom_range(255, 0));
      exp = model_ct(p, g, h, m, k);
      load_key(p, g, h);
      run_one($sformatf("rand%0d", t), m, k, exp);
    end

    // Reset mid-computation
    load_key(8'd23, 8'd5, 8'd8);
    start_req(8'd10, 8'd3);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ct_tvalid", 64'(bus.ct_tvalid), 64'd0);
    check("abort_key_tready", 64'(bus.key_tready), 64'd0);
    rst = 1'b0;
    bus.msg_tvalid = 1'b1;
    bus.eph_tvalid = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ct_tvalid || bus.msg_tready) bad++;
    end
    check("abort_quiet", 64'(bad), 64'd0);
    check("abort_key_ready", 64'(bus.key_tready), 64'd1);
    bus.msg_tvalid = 1'b0;
    bus.eph_tvalid = 1'b0;
    @(negedge clk);

    // Out-of-range plaintext
    load_key(8'd23, 8'd5, 8'd8);
    start_req(8'd30, 8'd3);
`ifdef ELGAMAL_ENC_RANGE_CHECK_EN
    check("range_err_pulse", 64'(bus.err), 64'd1);
    @(negedge clk);
    check("range_err_clear", 64'(bus.err), 64'd0);
    wait_ct(lat);
    check("range_no_ct", 64'(bus.ct_tvalid), 64'd0);
    check("range_idle", 64'(bus.key_tready), 64'd1);
`else
    check("range_no_err", 64'(bus.err), 64'd0);
    wait_ct(lat);
    check("range_lat", 64'(lat), 64'(LAT));
    take_ct();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
